rx_frame_buf: RTL and testbench
===============================

Name: rx_frame_buf

Overview:
Parametrised successor to the SPART receive shift register. It assembles a complete serial frame (data, optional parity, stop) from bit-centre strobes and a majority-averaged sample bit, then checks parity and framing. Completed words are queued in a small first-word-fall-through FIFO with a read handshake, so the processor bus interface can drain bytes without losing back-to-back frames. It sits between the rx start detector/baud sampler and the SPART bus interface.

Parameters:
DATA_W, 8, data bits per frame (5..16)
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity (used only when PARITY_EN=1)
MSB_FIRST, 0, 0 = LSB received first, 1 = MSB received first
DEPTH, 4, FIFO entries; power of 2, at least 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  start bit validated by the sampler; one-cycle pulse
shift  in  1  bit-centre strobe; one-cycle pulse
rx_in_avg  in  1  averaged rx sample, valid when shift=1
rd  in  1  consumer pops the head word
clr_ovr  in  1  clears the sticky overrun flag
rx_data  out  DATA_W  head word of the FIFO
rx_valid  out  1  FIFO not empty
parity_err  out  1  parity error flag of the head word
frame_err  out  1  stop-bit error flag of the head word
overrun  out  1  sticky: a frame was dropped because the FIFO was full
busy  out  1  frame assembly in progress (state != IDLE)
fill  out  clog2(DEPTH)+1  number of occupied FIFO entries

Behaviour:
- Reset is synchronous, active-high. clk and rst are the only clock and reset.
- Values on reset: state=IDLE; shift register all ones; bit counter 0; FIFO empty; rx_valid=0; fill=0; overrun=0; busy=0.
- Assembly FSM, four states:
  - IDLE: shift is ignored. start=1 moves to DATA and clears the bit counter.
  - DATA: each shift loads rx_in_avg into the shift register and increments the counter.
    - LSB-first: sr <= {rx_in_avg, sr[DATA_W-1:1]}.
    - MSB-first: sr <= {sr[DATA_W-2:0], rx_in_avg}.
    - On the DATA_W-th shift, go to PARITY if PARITY_EN=1, otherwise to STOP.
  - PARITY: on shift, capture the bit and go to STOP. perr = (^sr ^ bit) != PARITY_ODD.
  - STOP: on shift, ferr = ~rx_in_avg. Push {perr, ferr, sr} into the FIFO and go to IDLE. perr=0 when PARITY_EN=0.
- start is ignored outside IDLE. shift with start asserted in the same cycle in IDLE only starts the frame; that shift is not sampled.
- Push timing: the entry is written on the clk edge that ends the STOP-shift cycle. rx_valid and fill update on that same edge, so the word is visible the cycle after the stop strobe.
- FIFO is first-word fall-through:
  - rx_data, parity_err and frame_err always show the head entry.
  - When empty, rx_data is all ones and both error flags are 0.
- rd with rx_valid=1 pops the head on the next edge. rd with rx_valid=0 is ignored; pointers and fill do not change.
- Push and pop in the same cycle: both happen and fill is unchanged. This holds when full too: the pop frees the slot and the new word is accepted.
- Push while full with no pop: the new word is dropped, FIFO contents are unchanged, and overrun is set.
  - overrun clears only on clr_ovr=1 or rst.
  - If clr_ovr and a new overrun occur in the same cycle, set wins.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. fill ranges from 0 to DEPTH.
- Reset mid-frame discards the partial frame and empties the FIFO.

Test Plan:
- 8N1, LSB first: start, then shift with bits 1,0,1,0,0,1,0,1 and stop=1 -> rx_data=8'hA5, rx_valid=1 one cycle after the stop strobe, both error flags 0, fill=1.
- PARITY_EN=1, PARITY_ODD=0: data 8'h07 with parity bit 0 -> parity_err=1. Repeat with parity bit 1 -> parity_err=0.
- Stop bit sampled 0 on data 8'h3C -> rx_data=8'h3C, frame_err=1. The next clean frame shows frame_err=0 after rd.
- Five frames 8'h01..8'h05 with DEPTH=4 and no rd -> fill=4, overrun=1, reads return 01,02,03,04, then rx_valid=0 and rx_data=8'hFF. clr_ovr then clears overrun.
- FIFO full, rd asserted in the stop-strobe cycle of frame 8'h55 -> fill stays 4, overrun stays 0, last entry is 8'h55.
- MSB_FIRST=1, DATA_W=7: bits 1,1,0,0,1,0,1 -> rx_data=7'h65. Assert rst after three data bits -> busy=0, rx_valid=0, fill=0 next cycle.

Source files
------------

// File: rtl/rx_frame_buf.sv
// rtl/rx_frame_buf.sv - serial rx frame assembler with parity/stop checking
// and a first-word-fall-through word queue toward the bus interface.
module rx_frame_buf #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int MSB_FIRST  = 0,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     shift,
  input  logic                     rx_in_avg,
  input  logic                     rd,
  input  logic                     clr_ovr,
  output logic [DATA_W-1:0]        rx_data,
  output logic                     rx_valid,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]        state;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_next;
  logic [CW-1:0]     bit_cnt;
  logic              perr;
  logic              last_bit;

  // Entry layout: {parity error, frame error, data word}
  logic [DATA_W+1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;
  logic              full;
  logic              accept;

  assign last_bit = (bit_cnt == CW'(DATA_W - 1));

  always_comb begin
    sr_next = sr;
    if (MSB_FIRST != 0) sr_next = {sr[DATA_W-2:0], rx_in_avg};
    else                sr_next = {rx_in_avg, sr[DATA_W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      sr      <= '1;
      bit_cnt <= '0;
      perr    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_DATA;
            bit_cnt <= '0;
            perr    <= 1'b0;
          end
        end
        S_DATA: begin
          if (shift) begin
            sr      <= sr_next;
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (shift) begin
            perr  <= ((^sr) ^ rx_in_avg) != (PARITY_ODD != 0);
            state <= S_STOP;
          end
        end
        default: begin
          if (shift) state <= S_IDLE;
        end
      endcase
    end
  end

  assign push   = (state == S_STOP) && shift;
  assign pop    = rd && (count != '0);
  assign full   = (count == (AW + 1)'(DEPTH));
  // A same-cycle pop frees the slot, so a full queue still accepts
  assign accept = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (accept && !rst) mem[wr_ptr] <= {perr, ~rx_in_avg, sr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (!accept && pop) count <= count - 1'b1;
      if (push && !accept) overrun <= 1'b1;
      else if (clr_ovr)    overrun <= 1'b0;
    end
  end

  assign rx_valid   = (count != '0);
  assign rx_data    = rx_valid ? mem[rd_ptr][DATA_W-1:0] : '1;
  assign frame_err  = rx_valid & mem[rd_ptr][DATA_W];
  assign parity_err = rx_valid & mem[rd_ptr][DATA_W+1];
  assign busy       = (state != S_IDLE);
  assign fill       = count;

endmodule

// File: tb/tb_rx_frame_buf.sv
// tb/tb_rx_frame_buf.sv - self-checking bench for rx_frame_buf (8N1, 8E1, 7N1 MSB-first)
module tb_rx_frame_buf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] start_v, shift_v, bit_v, rd_v, clr_v;
  logic [2:0] valid_v, perr_v, ferr_v, ovr_v, busy_v;
  logic [2:0] fill_v [3];
  logic [7:0] d0, d1;
  logic [6:0] d2;

  rx_frame_buf #(.DATA_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .shift(shift_v[0]), .rx_in_avg(bit_v[0]),
    .rd(rd_v[0]), .clr_ovr(clr_v[0]), .rx_data(d0), .rx_valid(valid_v[0]),
    .parity_err(perr_v[0]), .frame_err(ferr_v[0]), .overrun(ovr_v[0]), .busy(busy_v[0]),
    .fill(fill_v[0]));

  rx_frame_buf #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .shift(shift_v[1]), .rx_in_avg(bit_v[1]),
    .rd(rd_v[1]), .clr_ovr(clr_v[1]), .rx_data(d1), .rx_valid(valid_v[1]),
    .parity_err(perr_v[1]), .frame_err(ferr_v[1]), .overrun(ovr_v[1]), .busy(busy_v[1]),
    .fill(fill_v[1]));

  rx_frame_buf #(.DATA_W(7), .MSB_FIRST(1)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .shift(shift_v[2]), .rx_in_avg(bit_v[2]),
    .rd(rd_v[2]), .clr_ovr(clr_v[2]), .rx_data(d2), .rx_valid(valid_v[2]),
    .parity_err(perr_v[2]), .frame_err(ferr_v[2]), .overrun(ovr_v[2]), .busy(busy_v[2]),
    .fill(fill_v[2]));

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;
  vec_t vt[7];

  logic [9:0] q[$];
  logic       m_ovr;
  logic [7:0] cur;
  int         rd_den;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] dout(input int i);
    case (i)
      0:       return d0;
      1:       return d1;
      default: return {1'b0, d2};
    endcase
  endfunction

  task automatic send_body(input int i, input logic [7:0] data, input logic par, input logic sh_start);
    int w;
    w = (i == 2) ? 7 : 8;
    start_v[i] = 1'b1;
    shift_v[i] = sh_start;
    bit_v[i]   = ~data[0];
    tick();
    start_v[i] = 1'b0;
    for (int b = 0; b < w; b++) begin
      shift_v[i] = 1'b1;
      bit_v[i]   = (i == 2) ? data[w-1-b] : data[b];
      tick();
    end
    shift_v[i] = 1'b0;
    if (i == 1) begin
      shift_v[i] = 1'b1;
      bit_v[i]   = par;
      tick();
      shift_v[i] = 1'b0;
    end
  endtask

  task automatic send_stop(input int i, input logic stop, input logic rd_s, input logic clr_s);
    shift_v[i] = 1'b1;
    bit_v[i]   = stop;
    rd_v[i]    = rd_s;
    clr_v[i]   = clr_s;
    tick();
    shift_v[i] = 1'b0;
    rd_v[i]    = 1'b0;
    clr_v[i]   = 1'b0;
  endtask

  task automatic send_frame(input int i, input logic [7:0] data, input logic par, input logic stop);
    send_body(i, data, par, 1'b0);
    send_stop(i, stop, 1'b0, 1'b0);
  endtask

  task automatic pop_word(input int i);
    rd_v[i] = 1'b1;
    tick();
    rd_v[i] = 1'b0;
  endtask

  task automatic check_head(input int i, input string nm, input logic [7:0] d,
                            input logic pe, input logic fe, input int f);
    chk({nm, "_valid"}, valid_v[i], 1'b1);
    chk({nm, "_data"}, dout(i), d);
    chk({nm, "_perr"}, perr_v[i], pe);
    chk({nm, "_ferr"}, ferr_v[i], fe);
    chk({nm, "_fill"}, fill_v[i], f);
  endtask

  // One cycle of the random run on u0; the model is a plain word queue
  task automatic rcycle(input logic s, input logic sh, input logic b,
                        input logic is_stop, input logic exp_busy);
    logic pop, full_b;
    start_v[0] = s;
    shift_v[0] = sh;
    bit_v[0]   = b;
    rd_v[0]    = ($urandom_range(0, rd_den - 1) == 0);
    clr_v[0]   = ($urandom_range(0, 9) == 0);
    pop    = rd_v[0] && (q.size() != 0);
    full_b = (q.size() == 4);
    if (pop) void'(q.pop_front());
    if (is_stop && full_b && !pop) m_ovr = 1'b1;
    else begin
      if (is_stop) q.push_back({1'b0, ~b, cur});
      if (clr_v[0]) m_ovr = 1'b0;
    end
    tick();
    start_v[0] = 1'b0; shift_v[0] = 1'b0; rd_v[0] = 1'b0; clr_v[0] = 1'b0;
    if (q.size() != 0) begin
      chk("rnd_data", d0, q[0][7:0]);
      chk("rnd_ferr", ferr_v[0], q[0][8]);
    end else begin
      chk("rnd_data", d0, 8'hFF);
      chk("rnd_ferr", ferr_v[0], 1'b0);
    end
    chk("rnd_perr", perr_v[0], 1'b0);
    chk("rnd_valid", valid_v[0], q.size() != 0);
    chk("rnd_fill", fill_v[0], q.size());
    chk("rnd_ovr", ovr_v[0], m_ovr);
    chk("rnd_busy", busy_v[0], exp_busy);
  endtask

  initial begin
    start_v = '0; shift_v = '0; bit_v = '0; rd_v = '0; clr_v = '0; rst = 1'b0;
    vt[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vt[2] = '{1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vt[3] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vt[4] = '{1, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
    vt[5] = '{1, 8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
    vt[6] = '{2, 8'h65, 1'b0, 1'b1, 8'h65, 1'b0, 1'b0};
    @(negedge clk);

    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("rst_valid", valid_v[i], 1'b0);
      chk("rst_fill", fill_v[i], 0);
      chk("rst_ovr", ovr_v[i], 1'b0);
      chk("rst_busy", busy_v[i], 1'b0);
      chk("rst_data", dout(i), (i == 2) ? 8'h7F : 8'hFF);
    end

    foreach (vt[k]) begin
      do_reset();
      send_frame(vt[k].dut, vt[k].data, vt[k].par, vt[k].stop);
      check_head(vt[k].dut, "vec", vt[k].exp_data, vt[k].exp_perr, vt[k].exp_ferr, 1);
    end

    // Word becomes visible exactly one cycle after the stop strobe
    do_reset();
    send_body(0, 8'hA5, 1'b0, 1'b0);
    chk("pre_stop_valid", valid_v[0], 1'b0);
    chk("pre_stop_busy", busy_v[0], 1'b1);
    send_stop(0, 1'b1, 1'b0, 1'b0);
    check_head(0, "a5", 8'hA5, 1'b0, 1'b0, 1);
    chk("a5_busy", busy_v[0], 1'b0);

    // Shift coinciding with start is not sampled
    do_reset();
    send_body(0, 8'h5A, 1'b0, 1'b1);
    send_stop(0, 1'b1, 1'b0, 1'b0);
    check_head(0, "st_sh", 8'h5A, 1'b0, 1'b0, 1);

    // Framing error word followed by a clean word
    do_reset();
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    send_frame(0, 8'hC3, 1'b0, 1'b1);
    check_head(0, "ferr1", 8'h3C, 1'b0, 1'b1, 2);
    pop_word(0);
    check_head(0, "ferr2", 8'hC3, 1'b0, 1'b0, 1);

    // Overflow: five frames into four entries
    do_reset();
    for (int n = 1; n <= 5; n++) send_frame(0, 8'(n), 1'b0, 1'b1);
    chk("ovf_fill", fill_v[0], 4);
    chk("ovf_ovr", ovr_v[0], 1'b1);
    for (int n = 1; n <= 4; n++) begin
      chk("ovf_rd", d0, 8'(n));
      pop_word(0);
    end
    chk("ovf_empty_valid", valid_v[0], 1'b0);
    chk("ovf_empty_data", d0, 8'hFF);
    pop_word(0);
    chk("empty_rd_fill", fill_v[0], 0);
    chk("ovf_sticky", ovr_v[0], 1'b1);
    clr_v[0] = 1'b1; tick(); clr_v[0] = 1'b0;
    chk("ovf_clr", ovr_v[0], 1'b0);

    // Full with a pop in the stop-strobe cycle
    do_reset();
    send_frame(0, 8'h11, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1);
    send_frame(0, 8'h33, 1'b0, 1'b1);
    send_frame(0, 8'h44, 1'b0, 1'b1);
    send_body(0, 8'h55, 1'b0, 1'b0);
    send_stop(0, 1'b1, 1'b1, 1'b0);
    chk("fullrd_fill", fill_v[0], 4);
    chk("fullrd_ovr", ovr_v[0], 1'b0);
    for (int n = 2; n <= 5; n++) begin
      chk("fullrd_rd", d0, 8'(n * 8'h11));
      pop_word(0);
    end
    for (int n = 0; n < 4; n++) send_frame(0, 8'hE0 + 8'(n), 1'b0, 1'b1);
    send_body(0, 8'h66, 1'b0, 1'b0);
    send_stop(0, 1'b1, 1'b0, 1'b1);
    chk("set_wins_ovr", ovr_v[0], 1'b1);
    chk("set_wins_head", d0, 8'hE0);

    // Reset mid-frame on the MSB-first 7-bit instance
    do_reset();
    send_frame(2, 8'h65, 1'b0, 1'b1);
    check_head(2, "msb", 8'h65, 1'b0, 1'b0, 1);
    start_v[2] = 1'b1; tick(); start_v[2] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      shift_v[2] = 1'b1; bit_v[2] = b[0]; tick();
    end
    shift_v[2] = 1'b0;
    chk("mid_busy", busy_v[2], 1'b1);
    do_reset();
    chk("mid_rst_busy", busy_v[2], 1'b0);
    chk("mid_rst_valid", valid_v[2], 1'b0);
    chk("mid_rst_fill", fill_v[2], 0);

    // Randomized run against the queue model
    do_reset();
    q.delete();
    m_ovr = 1'b0;
    for (int f = 0; f < 40; f++) begin
      logic stop_b;
      rd_den = (f < 15) ? 30 : 3;
      cur    = 8'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 2)) rcycle(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      rcycle(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b1);
      for (int b = 0; b < 8; b++) begin
        repeat ($urandom_range(0, 1)) rcycle(($urandom_range(0, 3) == 0), 1'b0, 1'b0, 1'b0, 1'b1);
        rcycle(($urandom_range(0, 3) == 0), 1'b1, cur[b], 1'b0, 1'b1);
      end
      repeat ($urandom_range(0, 1)) rcycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      rcycle(1'b0, 1'b1, stop_b, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
